// File: rtl/ram_arb_ctrl_if.sv
// Bus bundle for ram_arb_ctrl: two-requester command/response side plus the
// RAM write/read pins. slave = the controller's view, master = everything else.
interface ram_arb_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [1:0]              req_valid;
  logic [1:0]              req_we;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              req_ready;
  logic [1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    init_done;
  logic                    wr_enb;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_enb;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rd_data,
    output req_ready, rsp_valid, rsp_data, init_done,
           wr_enb, wr_addr, wr_data, rd_enb, rd_addr
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rd_data,
    input  req_ready, rsp_valid, rsp_data, init_done,
           wr_enb, wr_addr, wr_data, rd_enb, rd_addr
  );
endinterface

// File: rtl/ram_arb_ctrl.sv
// Two-requester round-robin front end for a 1W/1R synchronous RAM: zero-fills
// the array after reset, then issues one command per cycle and routes read data.
module ram_arb_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1,
  parameter bit INIT_EN    = 1'b1
) (
  input logic           clk,
  input logic           rst,
  ram_arb_ctrl_if.slave bus
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam state_t        RST_STATE = INIT_EN ? S_INIT : S_RUN;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            last_gnt;
  logic            init_done_q;
  logic            wr_enb_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic            rd_enb_q;
  logic [AW-1:0]   rd_addr_q;
  // read tags: stage k holds reads issued to the RAM k cycles ago
  logic [RD_LAT:0] vld_pipe;
  logic [RD_LAT:0] id_pipe;

  logic [1:0]      gnt;
  logic            hs;
  logic            hs_id;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // init_done doubles as the RUN qualifier so no grant overlaps the INIT sweep
  always_comb begin
    gnt = 2'b00;
    if (init_done_q) begin
      case (bus.req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign hs        = |gnt;
  assign hs_id     = gnt[1];
  assign sel_we    = hs_id ? bus.req_we[1] : bus.req_we[0];
  assign sel_addr  = hs_id ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
  assign sel_wdata = hs_id ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_STATE;
      cnt         <= '0;
      last_gnt    <= 1'b1;
      init_done_q <= 1'b0;
      wr_enb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_enb_q    <= 1'b0;
      rd_addr_q   <= '0;
      vld_pipe    <= '0;
      id_pipe     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], hs & ~sel_we};
      id_pipe  <= {id_pipe[RD_LAT-1:0], hs_id};
      case (state)
        S_INIT: begin
          wr_enb_q  <= 1'b1;
          wr_addr_q <= cnt;
          wr_data_q <= '0;
          rd_enb_q  <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_ADDR) state <= S_RUN;
        end
        S_RUN: begin
          init_done_q <= 1'b1;
          wr_enb_q    <= hs & sel_we;
          rd_enb_q    <= hs & ~sel_we;
          if (hs) begin
            last_gnt <= hs_id;
            if (sel_we) begin
              wr_addr_q <= sel_addr;
              wr_data_q <= sel_wdata;
            end else begin
              rd_addr_q <= sel_addr;
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready = gnt;
  assign bus.init_done = init_done_q;
  assign bus.wr_enb    = wr_enb_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_enb    = rd_enb_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rsp_valid = vld_pipe[RD_LAT] ? (id_pipe[RD_LAT] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = vld_pipe[RD_LAT] ? bus.rd_data : '0;
endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Bench for ram_arb_ctrl: hand sequences for INIT/reset/ordering, an arbitration
// vector table, and a random phase checked against a grant-order memory model.
module tb_ram_arb_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ram_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  ram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .INIT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM: write commits on the sampling edge, one-cycle registered read.
  // Holds non-zero junk while reset is high so the zero-fill is observable.
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) ram[i] <= DW'(8'hC0 ^ i);
    end else begin
      if (bus.wr_enb) ram[bus.wr_addr] <= bus.wr_data;
      if (bus.rd_enb) bus.rd_data <= ram[bus.rd_addr];
    end
  end

  typedef struct {
    logic [1:0] valid;
    logic [1:0] exp_ready;
  } vec_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input bit v, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[id]         = v;
    bus.req_we[id]            = we;
    bus.req_addr[id*AW +: AW] = a;
    bus.req_wdata[id*DW +: DW] = d;
  endtask

  task automatic clr_req();
    bus.req_valid = 2'b00;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.wr_enb, bus.wr_addr, bus.wr_data, bus.rd_enb, bus.rd_addr,
                bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.init_done});
  endfunction

  vec_t          vecs [14];
  rsp_t          q [$];
  rsp_t          r;
  logic [DW-1:0] mdl [2**AW];
  bit            pend [2];
  bit            pwe [2];
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  int            last_id;
  logic [1:0]    exp_rdy;
  logic [31:0]   exp_rsp;

  initial begin
    vecs[0]  = '{2'b01, 2'b01};
    vecs[1]  = '{2'b11, 2'b10};
    vecs[2]  = '{2'b11, 2'b01};
    vecs[3]  = '{2'b11, 2'b10};
    vecs[4]  = '{2'b01, 2'b01};
    vecs[5]  = '{2'b10, 2'b10};
    vecs[6]  = '{2'b10, 2'b10};
    vecs[7]  = '{2'b11, 2'b01};
    vecs[8]  = '{2'b00, 2'b00};
    vecs[9]  = '{2'b11, 2'b10};
    vecs[10] = '{2'b01, 2'b01};
    vecs[11] = '{2'b11, 2'b10};
    vecs[12] = '{2'b11, 2'b01};
    vecs[13] = '{2'b00, 2'b00};

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #2 check("reset_outputs", all_outs(), 32'h0);

    // INIT partway, then asynchronous reset at addr 7
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      check("init_a_addr", {bus.wr_enb, bus.wr_addr, bus.wr_data}, {1'b1, AW'(k), 8'h00});
    end
    #1 rst = 1'b1;
    #1 check("async_reset", all_outs(), 32'h0);
    set_req(1, 1'b1, 1'b0, 4'd2, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // full INIT from addr 0 with req1 read pending
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #2;
      check("init_wr", {bus.wr_enb, bus.wr_addr, bus.wr_data}, {1'b1, AW'(k), 8'h00});
      check("init_quiet", {bus.req_ready, bus.init_done, bus.rd_enb, bus.rsp_valid}, 32'h0);
    end
    @(posedge clk); #2;
    check("init_done", bus.init_done, 1);
    check("first_run_wr_off", bus.wr_enb, 0);
    check("first_run_grant", bus.req_ready, 2'b10);
    @(posedge clk); #1 clr_req();
    #1 check("pend_rd_issue", {bus.rd_enb, bus.rd_addr, bus.wr_enb}, {1'b1, 4'd2, 1'b0});
    @(posedge clk); #2 check("pend_rd_rsp", {bus.rsp_valid, bus.rsp_data}, {2'b10, 8'h00});

    // both requesters valid for six cycles
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
      set_req(1, 1'b1, 1'b0, 4'd4, 8'h00);
      #1 check("rr_both", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // read of a zero-filled location
    @(posedge clk); #1 clr_req(); set_req(0, 1'b1, 1'b0, 4'd9, 8'h00);
    #1 check("rd9_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1 clr_req();
    #1 check("rd9_issue", {bus.rd_enb, bus.rd_addr}, {1'b1, 4'd9});
    @(posedge clk); #2 check("rd9_rsp", {bus.rsp_valid, bus.rsp_data}, {2'b01, 8'h00});

    // write then read back, same requester
    @(posedge clk); #1 set_req(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    #1 check("wa5_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1 set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
    #1 check("wa5_wr_pins", {bus.wr_enb, bus.wr_addr, bus.wr_data, bus.rd_enb}, {1'b1, 4'd3, 8'hA5, 1'b0});
    check("ra5_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1 clr_req();
    #1 check("ra5_rd_pins", {bus.rd_enb, bus.rd_addr, bus.wr_enb}, {1'b1, 4'd3, 1'b0});
    @(posedge clk); #2 check("ra5_rsp", {bus.rsp_valid, bus.rsp_data}, {2'b01, 8'hA5});

    // req0 writes, req1 reads the same address
    @(posedge clk); #1 set_req(0, 1'b1, 1'b1, 4'd5, 8'h3C);
    #1 check("w3c_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1 clr_req(); set_req(1, 1'b1, 1'b0, 4'd5, 8'h00);
    #1 check("r3c_grant", bus.req_ready, 2'b10);
    @(posedge clk); #1 clr_req();
    #1 check("r3c_no_early_rsp", bus.rsp_valid, 2'b00);
    @(posedge clk); #2 check("r3c_rsp", {bus.rsp_valid, bus.rsp_data}, {2'b10, 8'h3C});

    // arbitration vector table (reads only)
    for (int v = 0; v < 14; v++) begin
      @(posedge clk); #1;
      set_req(0, vecs[v].valid[0], 1'b0, 4'd6, 8'h00);
      set_req(1, vecs[v].valid[1], 1'b0, 4'd7, 8'h00);
      #1 check("table_ready", bus.req_ready, vecs[v].exp_ready);
    end
    @(posedge clk); #1 clr_req();
    repeat (3) @(posedge clk);

    // random traffic against a grant-order memory model
    for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
    mdl[3] = 8'hA5;
    mdl[5] = 8'h3C;
    last_id = 0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && c < 390 && $urandom_range(0, 99) < 55) begin
          pend[i] = 1'b1;
          pwe[i]  = 1'($urandom_range(0, 1));
          pa[i]   = AW'($urandom_range(0, 2**AW - 1));
          pd[i]   = DW'($urandom);
        end
        set_req(i, pend[i], pwe[i], pa[i], pd[i]);
      end
      #1;
      if (pend[0] && pend[1]) exp_rdy = (last_id == 0) ? 2'b10 : 2'b01;
      else                    exp_rdy = {pend[1], pend[0]};
      check("rand_arb", bus.req_ready, exp_rdy);
      exp_rsp = 32'h0;
      if (q.size() > 0 && q[0].due == c) begin
        r = q.pop_front();
        exp_rsp = 32'({(r.id ? 2'b10 : 2'b01), r.data});
      end
      check("rand_rsp", 32'({bus.rsp_valid, bus.rsp_data}), exp_rsp);
      check("rand_wr_rd_excl", bus.wr_enb & bus.rd_enb, 0);
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && bus.req_ready[i]) begin
          last_id = i;
          if (pwe[i]) begin
            mdl[pa[i]] = pd[i];
          end else begin
            r.id   = 1'(i);
            r.data = mdl[pa[i]];
            r.due  = c + 2;
            q.push_back(r);
          end
          pend[i] = 1'b0;
        end
      end
    end
    check("rand_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arb_ctrl.md
Name: ram_arb_ctrl

Overview:
- Two-requester front-end controller for the team's single-write/single-read synchronous RAM.
- After reset, sweeps the whole array to zero (INIT).
- Then arbitrates read/write commands from two requesters round-robin, drives the RAM write/read pins one command per cycle, and routes read data back to the requester that issued it.
- Sits between the traffic agents/masters and the RAM's wr_*/rd_* pins.

Parameters:
- ADDR_WIDTH, 4, RAM address width; array depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width.
- RD_LAT, 1, cycles from rd_enb sampled by the RAM to valid rd_data (>=1).
- INIT_EN, 1, 1 = zero-fill the array after reset; 0 = skip INIT.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  2  per-requester command valid; bit i = requester i.
- req_we  input  2  per-requester command type: 1 = write, 0 = read.
- req_addr  input  2*ADDR_WIDTH  requester i address in bits [i*AW +: AW].
- req_wdata  input  2*DATA_WIDTH  requester i write data in bits [i*DW +: DW].
- req_ready  output  2  grant; handshake completes when req_valid[i] & req_ready[i].
- rsp_valid  output  2  one-cycle read-response strobe for requester i.
- rsp_data  output  DATA_WIDTH  read data; valid only when any rsp_valid bit is set.
- init_done  output  1  high once INIT is complete; stays high until reset.
- wr_enb  output  1  RAM write enable (registered).
- wr_addr  output  ADDR_WIDTH  RAM write address (registered).
- wr_data  output  DATA_WIDTH  RAM write data (registered).
- rd_enb  output  1  RAM read enable (registered).
- rd_addr  output  ADDR_WIDTH  RAM read address (registered).
- rd_data  input  DATA_WIDTH  RAM read data.

Behaviour:
- Reset, asynchronous and immediate: all outputs are 0, including wr_enb, rd_enb, addresses, wr_data, req_ready, rsp_valid, rsp_data and init_done.
  - FSM goes to INIT (or RUN if INIT_EN=0).
  - Round-robin pointer is set to favour requester 0.
  - In-flight read responses are discarded.
- FSM states:
  - INIT:
    - Counter runs 0..2**AW-1, one address per cycle starting the first clk edge after rst deasserts.
    - Each cycle drives wr_enb=1, wr_addr=count, wr_data=0; req_ready=0.
    - After the last address is driven, go to RUN; init_done=1 on the following cycle.
    - INIT lasts exactly 2**AW write cycles.
  - RUN:
    - Arbitrates every cycle; at most one command is granted per cycle.
    - With INIT_EN=0, init_done=1 the first cycle after rst deasserts.
- Arbitration (RUN only):
  - req_ready is combinational from req_valid and the pointer.
  - Only one valid: grant it.
  - Both valid: grant the requester not granted most recently.
  - Pointer updates only on a completed handshake.
  - req_ready is never asserted for a bit whose req_valid is 0.
  - Requesters hold valid/we/addr/wdata stable until granted.
- Issue timing (handshake in cycle T):
  - Write: wr_enb=1, wr_addr, wr_data on the RAM pins in cycle T+1.
  - Read: rd_enb=1, rd_addr in cycle T+1.
  - rd_enb/wr_enb drop in any cycle with no handshake.
  - Only one of wr_enb/rd_enb is high in any RUN cycle.
- Read response:
  - A tag pipeline of depth 1+RD_LAT carries {valid, requester id}.
  - rsp_valid[id]=1 and rsp_data=rd_data in cycle T+1+RD_LAT, for one cycle.
  - The other rsp_valid bit stays 0. rsp_data is 0 when no response is due.
  - No response backpressure; requesters must accept.
  - Back-to-back reads give back-to-back responses in issue order.
- Ordering:
  - Commands reach the RAM in grant order.
  - A read granted after a write to the same address returns the new data. This requires the RAM to commit a write on the edge it samples wr_enb.
  - No forwarding inside this block.
- Reset mid-operation (INIT or RUN): same as reset above.
  - A partially completed INIT restarts from address 0.
  - Pending rsp_valid never fires.
- Requests during INIT: req_ready stays 0, and requests remain pending until RUN.

Test Plan:
- Reset deassert, AW=4, INIT_EN=1 -> wr_enb=1 for 16 consecutive cycles, wr_addr 0..15, wr_data=0; init_done=1 one cycle after address 15; then read of addr 9 returns 0x00.
- Req0 write addr 3 data 0xA5 in cycle T, req0 read addr 3 in cycle T+1 -> wr_enb/wr_addr=3/wr_data=0xA5 at T+1; rd_enb/rd_addr=3 at T+2; rsp_valid=2'b01, rsp_data=0xA5 at T+3 (RD_LAT=1).
- Both requesters hold req_valid=1 for 6 cycles -> req_ready sequence 01,10,01,10,01,10; never 11.
- Req0 writes 0x3C to addr 5, then req1 reads addr 5 -> rsp_valid=2'b10, rsp_data=0x3C; rsp_valid[0] stays 0.
- Assert rst when INIT has reached addr 7 -> all outputs 0 in the same cycle, without waiting for clk; after release, INIT restarts at addr 0 and takes 16 cycles.
- Req1 holds a read of addr 2 from reset release -> req_ready[1]=0 throughout INIT; granted on the first RUN cycle; response arrives 2 cycles later.
